// File: rtl/multicore_sobel_switch_poller.sv
// multicore_sobel_switch_poller: polls a switch PIO over Avalon-MM, debounces it and streams change events.
// Define SWITCH_POLLER_IRQ_EN to add a registered irq output (evt_valid | overflow, one cycle behind).
module multicore_sobel_switch_poller #(
    parameter int DATA_W      = 3,
    parameter int ADDR_W      = 2,
    parameter int POLL_ADDR   = 0,
    parameter int POLL_CYCLES = 50000,
    parameter int DEBOUNCE    = 4,
    parameter int RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] sw_state,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_data,
    output logic [DATA_W-1:0] evt_changed,
    output logic              overflow,
    input  logic              overflow_clr
`ifdef SWITCH_POLLER_IRQ_EN
    ,
    output logic              irq
`endif
);
    localparam int TW = $clog2(POLL_CYCLES);
    localparam int LW = $clog2(RD_LAT + 1);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [TW-1:0] RELOAD = TW'(POLL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, READ, WAIT, EVAL} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic              rd_q, rd_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [DATA_W-1:0] cand_q, cand_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] sw_q, sw_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] chg_q, chg_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              match, raise, pend;
    logic [DATA_W-1:0] cand_n;
    logic [CW-1:0]     count_n;
    logic              unused_rdata;

    assign avm_address  = ADDR_W'(POLL_ADDR);
    assign avm_read     = rd_q;
    assign sw_state     = sw_q;
    assign evt_valid    = valid_q;
    assign evt_data     = data_q;
    assign evt_changed  = chg_q;
    assign overflow     = ovf_q;
    assign unused_rdata = ^avm_readdata;

    // Debounce result of the sample being evaluated; only committed in EVAL.
    assign match   = sample_q == cand_q;
    assign cand_n  = match ? cand_q : sample_q;
    assign count_n = !match ? CW'(1) : (count_q == CW'(DEBOUNCE)) ? count_q : count_q + CW'(1);
    assign raise   = (state_q == EVAL) && (count_n == CW'(DEBOUNCE)) && (cand_n != sw_q);
    assign pend    = valid_q && !evt_ready;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        lat_d    = lat_q;
        rd_d     = rd_q;
        sample_d = sample_q;
        cand_d   = cand_q;
        count_d  = count_q;
        sw_d     = sw_q;
        data_d   = data_q;
        chg_d    = chg_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (!enable) timer_d = RELOAD;
                else if (timer_q == '0) begin
                    state_d = READ;
                    rd_d    = 1'b1;
                end else timer_d = timer_q - TW'(1);
            end
            READ: begin
                if (!avm_waitrequest) begin
                    state_d = WAIT;
                    rd_d    = 1'b0;
                    lat_d   = LW'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d  = EVAL;
                    sample_d = avm_readdata[DATA_W-1:0];
                end else lat_d = lat_q - LW'(1);
            end
            default: begin
                state_d = IDLE;
                timer_d = RELOAD;
                cand_d  = cand_n;
                count_d = count_n;
            end
        endcase
        // A change that lands while the previous one is still unaccepted merges into it.
        if (raise) begin
            sw_d    = cand_n;
            data_d  = cand_n;
            chg_d   = pend ? (chg_q | (sw_q ^ cand_n)) : (sw_q ^ cand_n);
            valid_d = 1'b1;
        end else if (valid_q && evt_ready) valid_d = 1'b0;
        ovf_d = (raise && pend) || (ovf_q && !overflow_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= RELOAD;
            lat_q    <= '0;
            rd_q     <= 1'b0;
            sample_q <= '0;
            cand_q   <= '0;
            count_q  <= '0;
            sw_q     <= '0;
            data_q   <= '0;
            chg_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            lat_q    <= lat_d;
            rd_q     <= rd_d;
            sample_q <= sample_d;
            cand_q   <= cand_d;
            count_q  <= count_d;
            sw_q     <= sw_d;
            data_q   <= data_d;
            chg_q    <= chg_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef SWITCH_POLLER_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else irq <= valid_q | ovf_q;
    end
`endif
endmodule

// File: tb/tb_multicore_sobel_switch_poller.sv
// tb_multicore_sobel_switch_poller: randomized bench against a poll-schedule / sample-history reference model.
module tb_multicore_sobel_switch_poller;
    localparam int DW = 3;
    localparam int AW = 2;
    localparam int PA = 2;
    localparam int PC = 4;
    localparam int DB = 2;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic          avm_waitrequest = 1'b0;
    logic [31:0]   avm_readdata = '0;
    logic [DW-1:0] sw_state;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [DW-1:0] evt_data;
    logic [DW-1:0] evt_changed;
    logic          overflow;
    logic          overflow_clr = 1'b0;

    multicore_sobel_switch_poller #(
        .DATA_W(DW), .ADDR_W(AW), .POLL_ADDR(PA), .POLL_CYCLES(PC), .DEBOUNCE(DB), .RD_LAT(RL)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .sw_state(sw_state), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_data(evt_data), .evt_changed(evt_changed),
        .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Model: a poll is a scheduled sequence of cycle numbers; debounce is "last DB samples agree".
    bit            m_busy = 0;
    bit            m_rd = 0;
    int            m_stall = 0;
    int            m_idle = 0;
    int            m_sample_at = -1;
    int            m_eval_at = -1;
    logic [DW-1:0] m_cur = '0;
    logic [DW-1:0] m_sw = '0;
    logic [DW-1:0] m_ed = '0;
    logic [DW-1:0] m_ec = '0;
    bit            m_ev = 0;
    bit            m_ovf = 0;
    logic [DW-1:0] hist[$];
    logic [DW-1:0] vals[$];
    int            stalls[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit rdy, input bit clr);
        bit            raise;
        bit            set;
        logic [DW-1:0] v;
        @(negedge clk);
        reset        = rst;
        enable       = en;
        evt_ready    = rdy;
        overflow_clr = clr;
        avm_waitrequest = m_rd ? (m_stall > 0) : 1'($urandom_range(0, 1));
        avm_readdata = $urandom;
        avm_readdata[DW-1:0] = (cyc == m_sample_at) ? m_cur : m_cur ^ DW'($urandom_range(1, 7));
        @(posedge clk);
        raise = 0;
        v = '0;
        if (rst) begin
            m_busy = 0; m_rd = 0; m_idle = 0; m_sample_at = -1; m_eval_at = -1;
            m_sw = '0; m_ed = '0; m_ec = '0; m_ev = 0; m_ovf = 0;
            hist.delete();
        end else begin
            if (!m_busy) begin
                m_idle = en ? m_idle + 1 : 0;
                if (m_idle == PC) begin
                    m_busy = 1; m_rd = 1; m_idle = 0;
                    if (vals.size() != 0) m_cur = vals.pop_front();
                    else if ($urandom_range(0, 2) == 0) m_cur = DW'($urandom);
                    if (stalls.size() != 0) m_stall = stalls.pop_front();
                    else m_stall = $urandom_range(0, 3);
                end
            end else if (m_rd) begin
                if (avm_waitrequest) m_stall--;
                else begin
                    m_rd = 0;
                    m_sample_at = cyc + RL;
                    m_eval_at = cyc + RL + 1;
                end
            end else if (cyc == m_eval_at) begin
                hist.push_back(m_cur);
                if (hist.size() > DB) void'(hist.pop_front());
                v = hist[hist.size()-1];
                raise = (hist.size() == DB) && (v != m_sw);
                foreach (hist[i]) if (hist[i] != v) raise = 0;
                m_busy = 0;
                m_sample_at = -1;
                m_eval_at = -1;
            end
            set = raise && m_ev && !rdy;
            if (raise) begin
                m_ec = set ? (m_ec | (m_sw ^ v)) : (m_sw ^ v);
                m_ed = v; m_ev = 1; m_sw = v;
            end else if (m_ev && rdy) m_ev = 0;
            m_ovf = set || (m_ovf && !clr);
        end
        #1;
        chk("avm_read", avm_read, m_rd);
        chk("avm_address", avm_address, PA);
        chk("sw_state", sw_state, m_sw);
        chk("evt_valid", evt_valid, m_ev);
        chk("evt_data", evt_data, m_ed);
        chk("evt_changed", evt_changed, m_ec);
        chk("overflow", overflow, m_ovf);
        cyc++;
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_sw", sw_state, 0);
        chk("rst_read", avm_read, 0);
        // Constant 5, second poll stalled three cycles, consumer not ready.
        vals = '{3'd5, 3'd5};
        stalls = '{0, 3};
        repeat (20) step(0, 1, 0, 0);
        chk("a_sw", sw_state, 5);
        chk("a_valid", evt_valid, 1);
        chk("a_data", evt_data, 5);
        chk("a_changed", evt_changed, 5);
        // Glitch 5,2,5,5: only one change, to 5, after the fourth poll.
        step(1, 0, 0, 0);
        vals = '{3'd5, 3'd2, 3'd5, 3'd5};
        stalls = '{0, 0, 0, 0};
        repeat (25) step(0, 1, 1, 0);
        chk("b_sw_hold", sw_state, 0);
        repeat (5) step(0, 1, 1, 0);
        chk("b_sw", sw_state, 5);
        // Two changes with no consumer: merge and overflow, then clear.
        step(1, 0, 0, 0);
        vals = '{3'd5, 3'd5, 3'd1, 3'd1};
        stalls = '{0, 0, 0, 0};
        repeat (30) step(0, 1, 0, 0);
        chk("c_data", evt_data, 1);
        chk("c_changed", evt_changed, 5);
        chk("c_ovf", overflow, 1);
        step(0, 1, 0, 1);
        chk("c_ovf_clr", overflow, 0);
        // Reset while waiting on read data; next read after four enabled cycles.
        step(1, 0, 0, 0);
        vals = '{3'd3};
        stalls = '{0};
        repeat (5) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("d_sw", sw_state, 0);
        repeat (3) step(0, 1, 0, 0);
        chk("d_read_early", avm_read, 0);
        step(0, 1, 0, 0);
        chk("d_read", avm_read, 1);
        // Enable dropped mid-read: transaction finishes, then polling stops.
        step(1, 0, 0, 0);
        vals = '{3'd6};
        stalls = '{3};
        repeat (5) step(0, 1, 1, 0);
        repeat (12) step(0, 0, 1, 0);
        chk("e_read_off", avm_read, 0);
        // Randomized traffic with occasional resets.
        repeat (3000)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
